vcd_change_capture: RTL

//   Hardware value-change recorder; the capture stage feeding the VCD dump path.

---
 rtl/vcd_change_capture.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/vcd_change_capture.sv
// ---------------------------------------------------------------------------
// vcd_change_capture
//   Value-change recorder feeding the VCD dump path. The probe vector is
//   sampled every clock. When capture starts, one full-value record is
//   emitted. After that, one record is emitted per change, plus a snapshot
//   record whenever dump_all is pulsed. Records carry a free-running
//   timestamp and leave through a valid/ready FIFO.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     enable     capture enable (level)
//     probe      signals under observation
//     dump_all   one-cycle request for a full snapshot record
//     clr_ovf    clears the sticky overflow flag
//     out_valid  record available at the FIFO head
//     out_ready  downstream accepts the head record
//     out_time   timestamp of the head record
//     out_value  probe value of the head record
//     out_snap   1 = initial/snapshot record, 0 = change record
//     overflow   sticky: at least one record was dropped
//     level      current FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module vcd_change_capture #(
  parameter int WIDTH = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         probe,
  input  logic                     dump_all,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_time,
  output logic [WIDTH-1:0]         out_value,
  output logic                     out_snap,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  typedef struct packed {
    logic [TS_W-1:0]  t;
    logic [WIDTH-1:0] v;
    logic             s;
  } rec_t;

  state_t           state, state_nx;
  logic [TS_W-1:0]  ts;
  logic [WIDTH-1:0] last;

  rec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;

  logic             sample;     // capture is active this cycle: advance ts, update last
  logic             push_req;
  logic             push_snap;
  logic             pop, full, push_ok, drop;
  rec_t             head;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // ---------------- FSM: next-state ----------------
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable) state_nx = S_PRIME;
      S_PRIME: state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
    // Dropping enable stops capture from any active state.
    if (!enable) state_nx = S_IDLE;
  end

  // ---------------- FSM: outputs (push decision) ----------------
  always_comb begin
    sample    = 1'b0;
    push_req  = 1'b0;
    push_snap = 1'b0;
    case (state)
      S_PRIME: if (enable) begin
        sample    = 1'b1;
        push_req  = 1'b1;
        push_snap = 1'b1;
      end
      S_RUN: if (enable) begin
        sample = 1'b1;
        // A snapshot that coincides with a change already carries the new
        // value, so it absorbs the change record.
        if (dump_all) begin
          push_req  = 1'b1;
          push_snap = 1'b1;
        end else if (probe != last) begin
          push_req  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- timestamp and last-value tracking ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts   <= '0;
      last <= '0;
    end else if (sample) begin
      ts   <= ts + TS_W'(1);
      // Updated even when the record is dropped on a full FIFO, so the
      // next cycle does not emit a duplicate change.
      last <= probe;
    end
  end

  // ---------------- record FIFO ----------------
  assign pop     = out_valid && out_ready;
  assign full    = (count == LW'(DEPTH));
  // When full, a push fits only into the slot freed by a same-cycle pop.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(push_ok) - LW'(pop);
    end
  end

  // NOTE: the storage array is not reset. Occupancy is tracked by count, and
  // the head fields are masked while the FIFO is empty, so stale contents
  // are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{t: ts, v: probe, s: push_snap};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // ---------------- head outputs (registered state only) ----------------
  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_time  = out_valid ? head.t : '0;
  assign out_value = out_valid ? head.v : '0;
  assign out_snap  = out_valid ? head.s : 1'b0;
  assign level     = count;

endmodule
